// File: rtl/timer_debounce.sv
// -----------------------------------------------------------------------------
// timer_debounce
//
// Push-button debouncer wrapped around the board's one-shot timer. The raw
// button level is synchronised, and a change is only committed to level_out
// after STABLE_TICKS consecutive timer periods in which the synchronised level
// never disagreed with the candidate level. Each timer period is started with
// a one-cycle start_out pulse; the timer answers with a one-cycle tick_in.
//
// Handshake (start_out / tick_in): start_out is a one-cycle request that the
// timer always accepts, because ARM is only entered from IDLE or on the cycle
// after a tick, when the timer is known to be idle. tick_in is a one-cycle
// expiry pulse and is acted on only while waiting; anywhere else it is ignored.
//
// Optional feature (macro TIMER_DEBOUNCE_WDOG_EN): a WDOG_WIDTH-bit watchdog
// counts WAIT cycles without a tick. When it reaches all-ones the FSM gives
// up (back to IDLE, no commit) and wdog_err_out latches high until reset.
// Without the macro there is no watchdog and wdog_err_out is tied low.
//
// Ports:
//   clock_in      in   system clock, rising edge
//   reset_in      in   asynchronous active-low reset
//   button_in     in   raw asynchronous button level
//   tick_in       in   timer expiry pulse (one cycle)
//   start_out     out  timer start request (one cycle)
//   level_out     out  debounced button level
//   press_out     out  one-cycle pulse on committed 0->1
//   release_out   out  one-cycle pulse on committed 1->0
//   wdog_err_out  out  sticky watchdog error (0 without the feature)
//   state_dbg_out out  FSM state (IDLE=0, ARM=1, WAIT=2) for checkers
// -----------------------------------------------------------------------------
module timer_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4,
  parameter int TICK_WIDTH   = 3,
  parameter int WDOG_WIDTH   = 16
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       button_in,
  input  logic       tick_in,
  output logic       start_out,
  output logic       level_out,
  output logic       press_out,
  output logic       release_out,
  output logic       wdog_err_out,
  output logic [1:0] state_dbg_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Tick count value reached once STABLE_TICKS-1 clean periods are done;
  // the next clean tick commits.
  localparam logic [TICK_WIDTH-1:0] LAST_TICK = TICK_WIDTH'(STABLE_TICKS - 1);

  // Configurations outside the supported range show up as this named block
  // in the elaborated hierarchy.
  generate
    if (SYNC_STAGES < 2 || STABLE_TICKS < 1 ||
        STABLE_TICKS > (2 ** TICK_WIDTH - 1) || WDOG_WIDTH < 2) begin : g_illegal_params
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_w;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic                  cand_q, cand_d;
  logic                  dirty_q, dirty_d;
  logic [TICK_WIDTH-1:0] count_q, count_d;
  logic                  level_q, level_d;
  logic                  press_q, press_d;
  logic                  release_q, release_d;
  logic                  dirty_now;

`ifdef TIMER_DEBOUNCE_WDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
  logic [WDOG_WIDTH-1:0] wdog_inc;
  logic                  wdog_err_q, wdog_err_d;

  assign wdog_inc = wdog_q + 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    dirty_d   = dirty_q;
    count_d   = count_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef TIMER_DEBOUNCE_WDOG_EN
    wdog_d     = wdog_q;
    wdog_err_d = wdog_err_q;
`endif
    // The tick decision must see the sample taken in the tick cycle itself.
    dirty_now = dirty_q | (sync_w != cand_q);

    case (state_q)
      ST_IDLE: begin
        if (sync_w != level_q) begin
          cand_d  = sync_w;
          count_d = '0;
          dirty_d = 1'b0;
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        state_d = ST_WAIT;
`ifdef TIMER_DEBOUNCE_WDOG_EN
        wdog_d  = '0;
`endif
      end

      ST_WAIT: begin
        dirty_d = dirty_now;
        if (tick_in) begin
          if (dirty_now && (sync_w == level_q)) begin
            // Bounce settled back on the committed level: nothing to commit.
            dirty_d = 1'b0;
            state_d = ST_IDLE;
          end else if (dirty_now) begin
            // Bounce settled on the new level: restart the stability run.
            cand_d  = sync_w;
            count_d = '0;
            dirty_d = 1'b0;
            state_d = ST_ARM;
          end else if (count_q != LAST_TICK) begin
            count_d = count_q + 1'b1;
            state_d = ST_ARM;
          end else begin
            level_d   = cand_q;
            press_d   = cand_q;
            release_d = ~cand_q;
            state_d   = ST_IDLE;
          end
        end
`ifdef TIMER_DEBOUNCE_WDOG_EN
        else begin
          wdog_d = wdog_inc;
          if (wdog_inc == '1) begin
            wdog_err_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= ST_IDLE;
      cand_q    <= 1'b0;
      dirty_q   <= 1'b0;
      count_q   <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      dirty_q   <= dirty_d;
      count_q   <= count_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef TIMER_DEBOUNCE_WDOG_EN
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err_out = wdog_err_q;
`else
  assign wdog_err_out = 1'b0;
`endif

  assign start_out     = (state_q == ST_ARM);
  assign level_out     = level_q;
  assign press_out     = press_q;
  assign release_out   = release_q;
  assign state_dbg_out = state_q;

endmodule
